// File: rtl/move_ctrl_rpt.sv
`default_nettype none
// ============================================================================
//  Module   : move_ctrl_rpt
//  Purpose  : Game-board move controller with key priority, hold-to-repeat,
//             reject pulse and a saturating committed-move counter.
//             Detects rising edges on level key inputs, picks the lowest
//             index key, and runs a MOVE/STORE handshake with the datapath.
//  Ports    : clk        system clock
//             clr_n      asynchronous active-low reset
//             key        level key inputs (1 = pressed), synchronous to clk
//             move_able  datapath: requested move is legal (sampled in MOVE)
//             code       one-hot latched direction of the current move
//             move       1-cycle move request to the datapath
//             store      1-cycle commit strobe after an accepted move
//             reject     1-cycle pulse when a requested move is refused
//             busy       high whenever the controller is not idle
//             move_cnt   count of committed moves, saturating
//  Revision : 1.0  initial release
// ============================================================================
module move_ctrl_rpt #(
    parameter int NUM_KEYS   = 4,
    parameter int REPEAT_DLY = 8,
    parameter int REPEAT_PER = 4,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [NUM_KEYS-1:0] key,
    input  logic                move_able,
    output logic [NUM_KEYS-1:0] code,
    output logic                move,
    output logic                store,
    output logic                reject,
    output logic                busy,
    output logic [CNT_W-1:0]    move_cnt
);

    // Repeat counter only ever counts up to lim-1, so REP_MAX-1 is the
    // largest value it holds.
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = (REP_MAX < 2) ? 1 : $clog2(REP_MAX);

    localparam logic [REP_W-1:0] DLY_LAST = REP_W'((REPEAT_DLY == 0) ? 0 : REPEAT_DLY - 1);
    localparam logic [REP_W-1:0] PER_LAST = REP_W'((REPEAT_PER == 0) ? 0 : REPEAT_PER - 1);
    localparam logic             RPT_EN   = (REPEAT_DLY != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_STORE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_KEYS-1:0] code_q, code_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic                first_q, first_d;
    logic [NUM_KEYS-1:0] key_prev_q;
    logic                armed_q;

    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] sel;
    logic                rep_hit;

    // key_prev is cleared by reset, so the first clock after reset only
    // captures the key levels; armed_q suppresses a false press there.
    assign press   = armed_q ? (key & ~key_prev_q) : '0;
    // Isolate the lowest set bit: x & (~x + 1).
    assign sel     = press & (~press + NUM_KEYS'(1));
    assign rep_hit = (rep_q == (first_q ? DLY_LAST : PER_LAST));

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        first_d = first_q;
        move    = 1'b0;
        store   = 1'b0;
        reject  = 1'b0;
        busy    = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (|press) begin
                    state_d = ST_MOVE;
                    code_d  = sel;
                    first_d = 1'b1;
                end
            end
            ST_MOVE: begin
                move = 1'b1;
                if (move_able) begin
                    state_d = ST_STORE;
                end else begin
                    reject  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_STORE: begin
                store   = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = ST_HOLD;
                rep_d   = '0;
            end
            ST_HOLD: begin
                // A fresh press always wins over release and repeat timing.
                if (|press) begin
                    state_d = ST_MOVE;
                    code_d  = sel;
                    first_d = 1'b1;
                end else if ((key & code_q) == '0) begin
                    state_d = ST_IDLE;
                end else if (!RPT_EN) begin
                    state_d = ST_HOLD;
                end else if (rep_hit) begin
                    state_d = ST_MOVE;
                    first_d = 1'b0;
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            code_q     <= '0;
            cnt_q      <= '0;
            rep_q      <= '0;
            first_q    <= 1'b0;
            key_prev_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            rep_q      <= rep_d;
            first_q    <= first_d;
            key_prev_q <= key;
            armed_q    <= 1'b1;
        end
    end

    assign code     = code_q;
    assign move_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_move_ctrl_rpt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_move_ctrl_rpt
//  Purpose  : Self-checking bench for move_ctrl_rpt. Directed key sequences
//             push expected move/store events into queues; a monitor pops
//             and compares them as the design produces pulses. A second
//             instance with CNT_W=2 exercises counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_move_ctrl_rpt;

    typedef struct {
        int         cyc;
        logic [3:0] code;
        logic       rej;
    } ev_t;

    logic       clk;
    logic       clr_n;
    logic [3:0] key;
    logic       move_able;
    logic [3:0] code;
    logic       move, store, reject, busy;
    logic [7:0] move_cnt;

    logic [3:0] s_code;
    logic       s_move, s_store, s_reject, s_busy;
    logic [1:0] s_cnt;

    int   cyc;
    int   checks;
    int   errors;
    int   exp_cnt;
    int   exp_sat;
    ev_t  mq[$];
    ev_t  sq[$];

    move_ctrl_rpt #(.NUM_KEYS(4), .REPEAT_DLY(8), .REPEAT_PER(4), .CNT_W(8)) dut (
        .clk(clk), .clr_n(clr_n), .key(key), .move_able(move_able),
        .code(code), .move(move), .store(store), .reject(reject),
        .busy(busy), .move_cnt(move_cnt)
    );

    move_ctrl_rpt #(.NUM_KEYS(4), .REPEAT_DLY(8), .REPEAT_PER(4), .CNT_W(2)) dut_sat (
        .clk(clk), .clr_n(clr_n), .key(key), .move_able(move_able),
        .code(s_code), .move(s_move), .store(s_store), .reject(s_reject),
        .busy(s_busy), .move_cnt(s_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected move at cycle c; an accepted move also expects a store at c+1.
    task automatic exp_move(input int c, input logic [3:0] cd, input bit acc);
        ev_t e;
        e.cyc  = c;
        e.code = cd;
        e.rej  = !acc;
        mq.push_back(e);
        if (acc) begin
            e.cyc = c + 1;
            e.rej = 1'b0;
            sq.push_back(e);
        end
    endtask

    task automatic count_ok(input string tag);
        chk({tag, "_cnt"}, 32'(move_cnt), 32'(exp_cnt));
        chk({tag, "_sat"}, 32'(s_cnt), 32'(exp_sat));
    endtask

    task automatic bump_cnt;
        exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        exp_sat = (exp_sat == 3) ? 3 : exp_sat + 1;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (move === 1'b1) begin
            chk("move_expected", 32'(mq.size() > 0), 32'd1);
            if (mq.size() > 0) begin
                e = mq.pop_front();
                chk("move_cyc", 32'(cyc), 32'(e.cyc));
                chk("move_code", 32'(code), 32'(e.code));
                chk("move_reject", 32'(reject), 32'(e.rej));
            end
        end else if (reject === 1'b1) begin
            chk("reject_without_move", 32'(reject), 32'd0);
        end
        if (store === 1'b1) begin
            chk("store_expected", 32'(sq.size() > 0), 32'd1);
            if (sq.size() > 0) begin
                e = sq.pop_front();
                chk("store_cyc", 32'(cyc), 32'(e.cyc));
                chk("store_code", 32'(code), 32'(e.code));
            end
        end
    end

    initial begin
        int c;
        checks    = 0;
        errors    = 0;
        exp_cnt   = 0;
        exp_sat   = 0;
        key       = 4'b0000;
        move_able = 1'b1;
        clr_n     = 1'b1;

        // ---------------- reset state
        #2 clr_n = 1'b0;
        #1;
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_move", 32'(move), 32'd0);
        chk("rst_store", 32'(store), 32'd0);
        chk("rst_reject", 32'(reject), 32'd0);
        count_ok("rst");
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
        tick(2);

        // ---------------- single tap, accepted
        c = cyc;
        key = 4'b0001;
        exp_move(c + 1, 4'b0001, 1'b1);
        bump_cnt();
        tick(1);
        key = 4'b0000;
        chk("t1_busy1", 32'(busy), 32'd1);
        tick(1);
        chk("t1_busy2", 32'(busy), 32'd1);
        tick(1);
        chk("t1_busy3", 32'(busy), 32'd1);
        tick(1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_code", 32'(code), 32'h1);
        count_ok("t1");

        // ---------------- rejected press, held without repeat
        move_able = 1'b0;
        c = cyc;
        key = 4'b0100;
        exp_move(c + 1, 4'b0100, 1'b0);
        tick(2);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_code", 32'(code), 32'h4);
        tick(20);
        count_ok("t2");
        key = 4'b0000;
        move_able = 1'b1;
        tick(2);

        // ---------------- hold-to-repeat
        c = cyc;
        key = 4'b0010;
        exp_move(c + 1,  4'b0010, 1'b1);
        exp_move(c + 11, 4'b0010, 1'b1);
        exp_move(c + 17, 4'b0010, 1'b1);
        exp_move(c + 23, 4'b0010, 1'b1);
        exp_move(c + 29, 4'b0010, 1'b1);
        repeat (5) bump_cnt();
        tick(30);
        key = 4'b0000;
        tick(2);
        chk("t3_busy", 32'(busy), 32'd0);
        count_ok("t3");

        // ---------------- priority and new press in HOLD
        c = cyc;
        key = 4'b1010;
        exp_move(c + 1, 4'b0010, 1'b1);
        bump_cnt();
        tick(3);
        key = 4'b1001;
        exp_move(c + 4, 4'b0001, 1'b1);
        bump_cnt();
        tick(2);
        key = 4'b0000;
        tick(3);
        chk("t4_code", 32'(code), 32'h1);
        chk("t4_busy", 32'(busy), 32'd0);
        count_ok("t4");

        // ---------------- reset during STORE
        c = cyc;
        key = 4'b0100;
        mq.push_back('{c + 1, 4'b0100, 1'b0});
        tick(2);
        #1 clr_n = 1'b0;
        #1;
        exp_cnt = 0;
        exp_sat = 0;
        chk("t6a_store", 32'(store), 32'd0);
        chk("t6a_busy", 32'(busy), 32'd0);
        chk("t6a_move", 32'(move), 32'd0);
        chk("t6a_code", 32'(code), 32'd0);
        count_ok("t6a");
        tick(2);
        clr_n = 1'b1;
        tick(10);
        chk("t6a_held_busy", 32'(busy), 32'd0);
        key = 4'b0000;
        tick(2);

        // ---------------- reset during HOLD
        c = cyc;
        key = 4'b0100;
        exp_move(c + 1, 4'b0100, 1'b1);
        tick(3);
        chk("t6b_hold_busy", 32'(busy), 32'd1);
        #1 clr_n = 1'b0;
        #1;
        chk("t6b_busy", 32'(busy), 32'd0);
        chk("t6b_code", 32'(code), 32'd0);
        count_ok("t6b");
        tick(2);
        clr_n = 1'b1;
        tick(10);
        chk("t6b_held_busy", 32'(busy), 32'd0);
        key = 4'b0000;
        tick(2);

        // ---------------- counter saturation (CNT_W=2 instance)
        for (int i = 0; i < 8; i++) begin
            c = cyc;
            key = 4'b0001;
            exp_move(c + 1, 4'b0001, 1'b1);
            bump_cnt();
            tick(1);
            key = 4'b0000;
            tick(4);
            count_ok("t5");
        end

        chk("moves_outstanding", 32'(mq.size()), 32'd0);
        chk("stores_outstanding", 32'(sq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
